acc_port_ctrl: RTL and testbench
================================

ACC_PORT_CTRL -- requirements
Module: acc_port_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: number of PEs served, i.e. one PE column/row.
REQ-002 SHALL have parameter DEPTH, default 4: accumulator words per PE; this is fixed by the PE regfile and its 2-bit pointer.
REQ-003 SHALL have the following ports, with clock and reset listed first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_load  in  1  pulse; begin preload of N*DEPTH words
- start_drain  in  1  pulse; begin drain of N*DEPTH words
- ld_valid  in  1  host preload word valid
- ld_ready  out  1  block accepts preload word
- ld_data  in  32  preload word
- res_valid  out  1  drained word valid
- res_ready  in  1  host accepts drained word
- res_data  out  32  drained word
- res_last  out  1  marks final drained word
- busy  out  1  state is not IDLE
- pe_we  out  N  per-PE accumulator write enable
- pe_c  out  32  preload data, broadcast to all PEs
- pe_wben  out  N  per-PE writeback enable
- pe_out_ready  out  N  per-PE writeback strobe
- pe_out_sum  in  N*32  per-PE writeback data; PE i uses bits [32i+:32]

Function
REQ-004 SHALL implement the states IDLE, LOAD, DRN_REQ, DRN_WAIT, DRN_HOLD.
REQ-005 IDLE: start_load goes to LOAD; else start_drain goes to DRN_REQ. If both pulse in the same cycle, load wins and the drain is dropped.
REQ-006 Any start pulse outside IDLE SHALL be ignored.
REQ-007 LOAD: ld_ready=1. Each ld_valid&&ld_ready handshake with word index k (0..N*DEPTH-1) SHALL drive, registered one cycle later, pe_we[k/DEPTH]=1 for exactly one cycle and pe_c=ld_data.
REQ-008 Words SHALL be delivered in PE order; each PE places them in slots 0..DEPTH-1 through its own pointer increment.
REQ-009 After handshake k=N*DEPTH-1, ld_ready SHALL drop in the next cycle, and the state SHALL return to IDLE once the final pe_we pulse has issued.
REQ-010 DRN_REQ: pe_wben[p] and pe_out_ready[p] SHALL be 1 for exactly one cycle, where p is the current PE index. Then go to DRN_WAIT.
REQ-011 pe_wben[p] SHALL stay high for the whole drain of PE p, for all DEPTH words, and SHALL be 0 for every other PE.
REQ-012 DRN_WAIT: pe_out_ready=0. Capture pe_out_sum[32p+:32] into res_data, set res_valid=1, and go to DRN_HOLD. This gives 2 cycles from the strobe to res_valid.
REQ-013 DRN_HOLD: res_data SHALL be held stable until res_valid&&res_ready.
REQ-014 On that handshake, clear res_valid. If slot<DEPTH-1, increment slot and go to DRN_REQ. Else, if p<N-1, set slot=0, p=p+1, and go to DRN_REQ. Else go to IDLE.
REQ-015 At most one writeback request SHALL be outstanding at any time.
REQ-016 res_last SHALL be 1 with res_valid for p=N-1, slot=DEPTH-1, and 0 otherwise.
REQ-017 Word and PE counters SHALL wrap to 0 on return to IDLE, so back-to-back operations start at PE 0, slot 0.
REQ-018 The PE pointer SHALL end each full load or drain back at 0, given DEPTH increments modulo 4.
REQ-019 res_ready held high continuously SHALL sustain one word per 3 cycles.
REQ-020 res_ready low SHALL stall indefinitely without issuing further pe_out_ready pulses.

Reset
REQ-021 rst SHALL force state IDLE, all counters to 0, and all outputs to 0 (ld_ready, res_valid, res_data, res_last, busy, pe_we, pe_c, pe_wben, pe_out_ready).
REQ-022 rst mid-LOAD or mid-drain SHALL abort with no further PE strobes; the PEs share rst, so their pointers realign to slot 0.

Configuration
REQ-023 The macro ACC_PORT_ERR_EN SHALL control the err output.
REQ-024 With ACC_PORT_ERR_EN defined, SHALL add output err (1 bit), a sticky flag set the cycle after any start pulse arrives outside IDLE or both starts pulse together, and cleared only by rst.
REQ-025 Without ACC_PORT_ERR_EN, the err port SHALL be absent and such pulses are silently ignored per REQ-005/REQ-006.

Verification
REQ-026 N=4. Pulse start_load, stream words 0x100..0x10F with ld_valid constant -> pe_we one-hot 0001 for 4 pulses, then 0010, 0100, 1000, each one cycle after its handshake; pe_c matches each word; busy falls after the last pulse.
REQ-027 Preload as above, then start_drain with res_ready=1 -> 16 words 0x100..0x10F in order; each word appears 2 cycles after its pe_out_ready strobe; res_last only on 0x10F.
REQ-028 Drain with res_ready low for 10 cycles on word 5 -> res_data=0x105 held stable, no pe_out_ready pulses during the stall; the sequence completes unchanged.
REQ-029 Assert rst during word 7 of a drain, then preload 0x200..0x20F and drain -> all outputs 0 at rst; second drain returns 0x200..0x20F in order.
REQ-030 Pulse start_load and start_drain in the same cycle in IDLE, then pulse start_drain during LOAD -> only LOAD executes; with ACC_PORT_ERR_EN defined, err=1 and stays 1 until rst.

Source files
------------

// File: rtl/acc_port_ctrl.sv
// rtl/acc_port_ctrl.sv - PE accumulator preload/drain port controller; optional err output under ACC_PORT_ERR_EN
module acc_port_ctrl #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_load,
    input  logic            start_drain,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [31:0]     ld_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_data,
    output logic            res_last,
    output logic            busy,
    output logic [N-1:0]    pe_we,
    output logic [31:0]     pe_c,
    output logic [N-1:0]    pe_wben,
    output logic [N-1:0]    pe_out_ready,
    input  logic [N*32-1:0] pe_out_sum
`ifdef ACC_PORT_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRN_REQ, DRN_WAIT, DRN_HOLD} state_t;

    state_t          state;
    logic [PW-1:0]   pe_idx;
    logic [SW-1:0]   slot;
    logic            last_slot;
    logic            last_pe;
    logic [PW-1:0]   nxt_pe;
    logic [31:0]     sel_sum;

    function automatic logic [N-1:0] pe_sel(input logic [PW-1:0] p);
        pe_sel = N'(1) << p;
    endfunction

    assign last_slot = (slot == SW'(DEPTH - 1));
    assign last_pe   = (pe_idx == PW'(N - 1));
    assign nxt_pe    = last_slot ? pe_idx + PW'(1) : pe_idx;
    assign sel_sum   = pe_out_sum[int'(pe_idx) * 32 +: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pe_idx       <= '0;
            slot         <= '0;
            ld_ready     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_last     <= 1'b0;
            busy         <= 1'b0;
            pe_we        <= '0;
            pe_c         <= '0;
            pe_wben      <= '0;
            pe_out_ready <= '0;
`ifdef ACC_PORT_ERR_EN
            err          <= 1'b0;
`endif
        end else begin
            pe_we        <= '0;
            pe_out_ready <= '0;
`ifdef ACC_PORT_ERR_EN
            if ((start_load && start_drain) || (state != IDLE && (start_load || start_drain)))
                err <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start_drain) begin
                        state        <= DRN_REQ;
                        pe_wben      <= pe_sel(pe_idx);
                        pe_out_ready <= pe_sel(pe_idx);
                        busy         <= 1'b1;
                    end
                end
                LOAD: begin
                    // ld_ready low while still in LOAD marks the final pe_we cycle
                    if (!ld_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ld_valid) begin
                        pe_we  <= pe_sel(pe_idx);
                        pe_c   <= ld_data;
                        slot   <= last_slot ? '0 : slot + SW'(1);
                        pe_idx <= (last_slot && last_pe) ? '0 : nxt_pe;
                        if (last_slot && last_pe)
                            ld_ready <= 1'b0;
                    end
                end
                DRN_REQ: begin
                    state <= DRN_WAIT;
                end
                DRN_WAIT: begin
                    res_data  <= sel_sum;
                    res_valid <= 1'b1;
                    res_last  <= last_slot && last_pe;
                    state     <= DRN_HOLD;
                end
                DRN_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        slot      <= last_slot ? '0 : slot + SW'(1);
                        pe_idx    <= (last_slot && last_pe) ? '0 : nxt_pe;
                        if (last_slot && last_pe) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            pe_wben <= '0;
                        end else begin
                            state        <= DRN_REQ;
                            pe_wben      <= pe_sel(nxt_pe);
                            pe_out_ready <= pe_sel(nxt_pe);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_port_ctrl.sv
// tb/tb_acc_port_ctrl.sv - randomized self-checking bench for acc_port_ctrl with PE regfile model; err checks under ACC_PORT_ERR_EN
module tb_acc_port_ctrl;
    localparam int N = 4;
    localparam int DEPTH = 4;
    localparam int W = N * DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start_load, start_drain, ld_valid, ld_ready;
    logic [31:0]     ld_data, res_data, pe_c;
    logic            res_valid, res_ready, res_last, busy;
    logic [N-1:0]    pe_we, pe_wben, pe_out_ready;
    logic [N*32-1:0] pe_out_sum;
`ifdef ACC_PORT_ERR_EN
    logic            err;
`endif

    acc_port_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_drain(start_drain),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .pe_we(pe_we), .pe_c(pe_c), .pe_wben(pe_wben),
        .pe_out_ready(pe_out_ready), .pe_out_sum(pe_out_sum)
`ifdef ACC_PORT_ERR_EN
        , .err(err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        onehot = '0;
        if (p >= 0 && p < N) onehot[p] = 1'b1;
    endfunction

    // PE regfile: 2-bit pointer advanced by every write and every writeback strobe
    logic [31:0] pe_mem [N][DEPTH];
    logic [1:0]  pe_ptr [N];
    logic [31:0] pe_sum [N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                pe_ptr[i] <= 2'd0;
                pe_sum[i] <= 32'd0;
            end else if (pe_we[i]) begin
                pe_mem[i][pe_ptr[i]] <= pe_c;
                pe_ptr[i] <= pe_ptr[i] + 2'd1;
            end else if (pe_wben[i] && pe_out_ready[i]) begin
                pe_sum[i] <= pe_mem[i][pe_ptr[i]];
                pe_ptr[i] <= pe_ptr[i] + 2'd1;
            end
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_sum
        assign pe_out_sum[32*g +: 32] = pe_sum[g];
    end

    // Transaction-level model: mode, word counts, and the words most recently loaded
    int          m_mode = 0;
    int          m_k = 0;
    int          m_j = 0;
    bit          m_tail = 0;
    bit          m_err = 0;
    bit          p_rst = 0;
    bit          p_hs = 0;
    int          p_hs_k = 0;
    logic [31:0] p_hs_d = 0;
    logic [31:0] exp_words [$];

    always @(posedge clk) begin
        p_rst = rst;
        p_hs = 0;
        if (rst) begin
            m_mode = 0; m_tail = 0; m_k = 0; m_j = 0; m_err = 0;
        end else begin
            if ((start_load && start_drain) || (m_mode != 0 && (start_load || start_drain)))
                m_err = 1;
            case (m_mode)
                0: if (start_load) begin
                       m_mode = 1; m_k = 0; exp_words.delete();
                   end else if (start_drain) begin
                       m_mode = 2; m_j = 0;
                   end
                1: if (m_tail) begin
                       m_mode = 0; m_tail = 0;
                   end else if (ld_valid && ld_ready) begin
                       p_hs = 1; p_hs_k = m_k; p_hs_d = ld_data;
                       exp_words.push_back(ld_data);
                       m_k++;
                       if (m_k == W) m_tail = 1;
                   end
                default: if (res_valid && res_ready) begin
                       m_j++;
                       if (m_j == W) m_mode = 0;
                   end
            endcase
        end
    end

    int          cyc = 0;
    int          strobe_cyc = 0;
    int          run = 0;
    int          last_run = 0;
    bit          pending = 0;
    bit          prev_valid = 0;
    bit          lit_on = 0;
    logic [31:0] lit_base = 0;

    always @(negedge clk) begin
        cyc++;
        if (p_rst) begin
            check("reset_ctl", {ld_ready, res_valid, res_last, busy, pe_we, pe_wben, pe_out_ready}, 64'd0);
            check("reset_data", {res_data, pe_c}, 64'd0);
            pending = 0;
            prev_valid = 0;
        end else begin
            check("busy", busy, m_mode != 0);
            check("ld_ready", ld_ready, m_mode == 1 && !m_tail);
            check("pe_we", pe_we, p_hs ? onehot(p_hs_k / DEPTH) : '0);
            if (p_hs) check("pe_c", pe_c, p_hs_d);
            check("pe_wben", pe_wben, (m_mode == 2) ? onehot(m_j / DEPTH) : '0);
            if (pe_out_ready != '0) begin
                check("strobe", {pending, res_valid, pe_out_ready}, {2'b00, onehot(m_j / DEPTH)});
                pending = 1;
                strobe_cyc = cyc;
            end
            if (res_valid && !prev_valid) begin
                check("strobe_to_valid", pending ? cyc - strobe_cyc : -1, 2);
                pending = 0;
            end
            if (res_valid) begin
                if (m_j < exp_words.size()) begin
                    check("res_data", res_data, exp_words[m_j]);
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL res_data: word index %0d got %0h expected no word", m_j, res_data);
                end
                check("res_last", res_last, m_j == W - 1);
                if (lit_on) check("res_data_lit", res_data, lit_base + 32'(m_j));
            end else begin
                check("res_last_idle", res_last, 1'b0);
            end
            prev_valid = res_valid;
        end
`ifdef ACC_PORT_ERR_EN
        check("err", err, m_err);
`endif
        if (busy) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic timeout(input string name, input int got, input int need);
        n_cmp++; n_bad++;
        $display("FAIL %s: got %0d expected %0d", name, got, need);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy) timeout("idle_timeout", t, 2000);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] base, input bit rnd, input int gap,
                           input bit dual, input int poke_idx, input int poke_pct);
        logic [31:0] w [W];
        int idx, t;
        for (int i = 0; i < W; i++) w[i] = rnd ? $urandom : base + 32'(i);
        @(negedge clk); start_load = 1; start_drain = dual;
        @(negedge clk); start_load = 0; start_drain = 0;
        idx = 0; t = 0;
        while (idx < W && t < 2000) begin
            ld_valid = ($urandom_range(0, 99) >= gap);
            ld_data = w[idx];
            start_drain = (idx == poke_idx) || ($urandom_range(0, 99) < poke_pct);
            if (ld_valid && ld_ready) idx++;
            @(negedge clk);
            t++;
        end
        ld_valid = 0; start_drain = 0;
        if (idx < W) timeout("load_words", idx, W);
        wait_idle();
    endtask

    task automatic do_drain(input int stall_pct, input int stall_word, input int stall_len,
                            input int rst_word, input int poke_pct);
        int nw = 0, t = 0, stall = 0;
        bit aborted = 0;
        @(negedge clk); start_drain = 1;
        @(negedge clk); start_drain = 0;
        while (busy && t < 3000) begin
            if (rst_word >= 0 && nw == rst_word && res_valid) begin
                rst = 1; res_ready = 0; start_load = 0;
                @(negedge clk);
                @(negedge clk);
                rst = 0;
                aborted = 1;
                break;
            end
            if (stall_word >= 0 && nw == stall_word && res_valid && stall < stall_len) begin
                res_ready = 0;
                stall++;
                check("stall_hold", res_data, lit_base + 32'(stall_word));
                check("stall_no_strobe", pe_out_ready, '0);
            end else begin
                res_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            start_load = ($urandom_range(0, 99) < poke_pct);
            if (res_valid && res_ready) nw++;
            @(negedge clk);
            t++;
        end
        res_ready = 0; start_load = 0;
        if (!aborted) begin
            if (busy) timeout("drain_timeout", t, 3000);
            check("drain_words", nw, W);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; start_load = 0; start_drain = 0; ld_valid = 0; ld_data = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);

        lit_on = 1; lit_base = 32'h100;
        do_load(32'h100, 0, 0, 0, -1, 0);
        check("load_busy_cycles", last_run, 17);
        check("pe_mem_0_0", pe_mem[0][0], 32'h100);
        check("pe_mem_1_2", pe_mem[1][2], 32'h106);
        check("pe_mem_3_3", pe_mem[3][3], 32'h10F);
        check("pe_ptr_wrap", {pe_ptr[0], pe_ptr[1], pe_ptr[2], pe_ptr[3]}, 0);

        do_drain(0, -1, 0, -1, 0);
        check("drain_busy_cycles", last_run, 48);

        do_drain(0, 5, 10, -1, 0);
        do_drain(0, -1, 0, 7, 0);

        lit_base = 32'h200;
        do_load(32'h200, 0, 0, 0, -1, 0);
        do_drain(0, -1, 0, -1, 0);
        check("drain2_busy_cycles", last_run, 48);

        lit_base = 32'h300;
        do_load(32'h300, 0, 0, 1, 5, 0);
        check("dual_start_load_only", last_run, 17);
        repeat (3) @(negedge clk);
`ifdef ACC_PORT_ERR_EN
        check("err_sticky", err, 1'b1);
`endif
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
`ifdef ACC_PORT_ERR_EN
        check("err_cleared", err, 1'b0);
`endif

        lit_on = 0;
        for (int it = 0; it < 6; it++) begin
            do_load(0, 1, $urandom_range(0, 60), ($urandom_range(0, 3) == 0), -1, 5);
            do_drain($urandom_range(0, 60), -1, 0, -1, 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
